// File: rtl/tlul_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tlul_arb_pkg : default sizing and host-index type for the TL-UL host arbiter
// Revision     : 1.0
// ----------------------------------------------------------------------------
package tlul_arb_pkg;

  localparam int NumHostsDefault       = 2;
  localparam int MaxOutstandingDefault = 4;
  localparam int HostIdxW              = $clog2(NumHostsDefault);

  typedef logic [HostIdxW-1:0] host_idx_t;

endpackage
`default_nettype wire

// File: rtl/tlul_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tlul_pkg : TileLink-UL host-to-device and device-to-host bus structures
// Revision : 1.0
// ----------------------------------------------------------------------------
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage
`default_nettype wire

// File: rtl/tlul_host_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tlul_host_arb_if : host-side and device-side TL-UL buses of the arbiter
// Revision         : 1.0
// ----------------------------------------------------------------------------
interface tlul_host_arb_if #(
  parameter int NumHosts = tlul_arb_pkg::NumHostsDefault
);

  tlul_pkg::tl_h2d_t [NumHosts-1:0] tl_h_i;
  tlul_pkg::tl_d2h_t [NumHosts-1:0] tl_h_o;
  tlul_pkg::tl_h2d_t                tl_d_o;
  tlul_pkg::tl_d2h_t                tl_d_i;

  // slave: the arbiter itself; master: the hosts plus the shared device
  modport slave  (input tl_h_i, output tl_h_o, output tl_d_o, input tl_d_i);
  modport master (output tl_h_i, input tl_h_o, input tl_d_o, output tl_d_i);

endinterface
`default_nettype wire

// File: rtl/tlul_arb_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tlul_arb_fifo : synchronous FIFO of host indices with occupancy count
// Revision      : 1.0
// ----------------------------------------------------------------------------
module tlul_arb_fifo
  import tlul_arb_pkg::*;
#(
  parameter  int Width = $bits(host_idx_t),
  parameter  int Depth = MaxOutstandingDefault,
  localparam int PtrW  = $clog2(Depth),
  localparam int CntW  = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Depth-1:0][Width-1:0] mem_q, mem_d;
  logic [PtrW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic                        do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  // A push into a full queue is dropped even when a pop frees a slot this cycle
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlul_host_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tlul_host_arb : round-robin TL-UL host arbiter sharing one device port
// Revision      : 1.0
// ----------------------------------------------------------------------------
module tlul_host_arb
  import tlul_pkg::*;
  import tlul_arb_pkg::*;
#(
  parameter  int NumHosts       = NumHostsDefault,
  parameter  int MaxOutstanding = MaxOutstandingDefault,
  localparam int IdxW           = $clog2(NumHosts),
  localparam int CntW           = $clog2(MaxOutstanding) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  tlul_host_arb_if.slave  bus,
  output logic [CntW-1:0] outstanding_o,
  output logic            idle_o,
  output logic            err_o
);

  logic            locked_q, locked_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic            err_q, err_d;

  logic [IdxW-1:0] gnt_idx, head_idx;
  logic            gnt_found, gnt_req, a_valid_out;
  logic            full, empty, accept, pop, any_req;
  logic [CntW-1:0] count;

  // Grant selection: a held lock wins, otherwise rotate from the last winner
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    if (locked_q) begin
      gnt_found = 1'b1;
      gnt_idx   = lock_idx_q;
    end else begin
      for (int k = 1; k <= NumHosts; k++) begin
        if (!gnt_found &&
            bus.tl_h_i[IdxW'((int'(last_grant_q) + k) % NumHosts)].a_valid) begin
          gnt_found = 1'b1;
          gnt_idx   = IdxW'((int'(last_grant_q) + k) % NumHosts);
        end
      end
    end
  end

  assign gnt_req     = gnt_found & bus.tl_h_i[gnt_idx].a_valid;
  assign a_valid_out = gnt_req & ~full;
  assign accept      = a_valid_out & bus.tl_d_i.a_ready;
  assign pop         = bus.tl_d_i.d_valid & ~empty & bus.tl_h_i[head_idx].d_ready;

  always_comb begin
    bus.tl_d_o         = bus.tl_h_i[gnt_idx];
    bus.tl_d_o.a_valid = a_valid_out;
    // With nothing outstanding any response is stray and is drained here
    bus.tl_d_o.d_ready = empty ? 1'b1 : bus.tl_h_i[head_idx].d_ready;
    any_req            = 1'b0;
    for (int i = 0; i < NumHosts; i++) begin
      bus.tl_h_o[i]         = bus.tl_d_i;
      bus.tl_h_o[i].a_ready = gnt_found && (gnt_idx == IdxW'(i)) &&
                              bus.tl_d_i.a_ready && !full;
      bus.tl_h_o[i].d_valid = bus.tl_d_i.d_valid && !empty && (head_idx == IdxW'(i));
      any_req               = any_req | bus.tl_h_i[i].a_valid;
    end
  end

  // A requesting grantee that is not accepted (device stall or full queue)
  // keeps the grant so its held request cannot be overtaken.
  always_comb begin
    locked_d     = locked_q;
    lock_idx_d   = lock_idx_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      locked_d     = 1'b0;
      last_grant_d = gnt_idx;
    end else if (gnt_req) begin
      locked_d   = 1'b1;
      lock_idx_d = gnt_idx;
    end
    err_d = bus.tl_d_i.d_valid & empty;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_q     <= 1'b0;
      lock_idx_q   <= '0;
      last_grant_q <= IdxW'(NumHosts - 1);
      err_q        <= 1'b0;
    end else begin
      locked_q     <= locked_d;
      lock_idx_q   <= lock_idx_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  tlul_arb_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) u_trk_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .wdata_i (gnt_idx),
    .pop_i   (pop),
    .rdata_o (head_idx),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign outstanding_o = count;
  assign idle_o        = (count == '0) && !any_req;
  assign err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tlul_host_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tlul_host_arb : scoreboard bench with a queue-based arbiter reference
// Revision         : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tlul_host_arb;
  import tlul_pkg::*;

  localparam int NH   = 2;
  localparam int MAXO = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] outstanding;
  logic       idle, err;

  tlul_host_arb_if #(.NumHosts(NH)) bus ();

  tlul_host_arb #(.NumHosts(NH), .MaxOutstanding(MAXO)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus           (bus),
    .outstanding_o (outstanding),
    .idle_o        (idle),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endfunction

  function automatic logic [31:0] rsp_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          host;
    logic [31:0] data;
  } rsp_t;

  int   m_owner, m_last;
  int   m_trk[$];
  bit   m_err_pend;
  rsp_t sb[$];

  always @(negedge clk) begin : monitor
    int   head;
    bit   full, exp_av, acc, hs_d, any_v;
    rsp_t r;
    if (!rst_n) begin
      m_owner    = -1;
      m_last     = NH - 1;
      m_err_pend = 1'b0;
      m_trk.delete();
      sb.delete();
    end else begin
      if (m_owner < 0) begin
        for (int k = 1; k <= NH; k++) begin
          if (m_owner < 0 && bus.tl_h_i[(m_last + k) % NH].a_valid) m_owner = (m_last + k) % NH;
        end
      end
      full   = (m_trk.size() == MAXO);
      head   = (m_trk.size() > 0) ? m_trk[0] : -1;
      any_v  = 1'b0;
      for (int i = 0; i < NH; i++) any_v |= bus.tl_h_i[i].a_valid;
      exp_av = (m_owner >= 0) && bus.tl_h_i[m_owner].a_valid && !full;

      check("dev_a_valid", 32'(bus.tl_d_o.a_valid), 32'(exp_av));
      if (exp_av) check("dev_a_address", bus.tl_d_o.a_address, bus.tl_h_i[m_owner].a_address);
      for (int i = 0; i < NH; i++) begin
        check("host_a_ready", 32'(bus.tl_h_o[i].a_ready),
              32'((i == m_owner) && bus.tl_d_i.a_ready && !full));
        check("host_d_valid", 32'(bus.tl_h_o[i].d_valid),
              32'(bus.tl_d_i.d_valid && (head == i)));
      end
      check("dev_d_ready", 32'(bus.tl_d_o.d_ready),
            32'((head < 0) ? 1'b1 : bus.tl_h_i[head].d_ready));
      check("outstanding", 32'(outstanding), 32'(m_trk.size()));
      check("idle", 32'(idle), 32'((m_trk.size() == 0) && !any_v));
      check("err", 32'(err), 32'(m_err_pend));

      for (int i = 0; i < NH; i++) begin
        if (bus.tl_h_o[i].d_valid && bus.tl_h_i[i].d_ready) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected_host", 32'(i), 32'hFFFF_FFFF);
          end else begin
            r = sb.pop_front();
            check("rsp_host", 32'(i), 32'(r.host));
            check("rsp_data", bus.tl_h_o[i].d_data, r.data);
          end
        end
      end

      acc        = exp_av && bus.tl_d_i.a_ready;
      hs_d       = bus.tl_d_i.d_valid && (head >= 0) && bus.tl_h_i[head].d_ready;
      m_err_pend = bus.tl_d_i.d_valid && (head < 0);
      if (hs_d) void'(m_trk.pop_front());
      if (acc) begin
        m_trk.push_back(m_owner);
        r.host = m_owner;
        r.data = rsp_data(bus.tl_h_i[m_owner].a_address);
        sb.push_back(r);
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  end

  // ---------------- host / device stimulus ----------------
  logic [31:0] hq[NH][$];
  logic [31:0] dev_q[$];
  int          acc_log[$];
  int          rsp_log[$];
  int          p_ard = 100, p_dv = 100, p_dr = 100;
  bit          dev_dv = 1'b0, inject_unexp = 1'b0, unexp_cur = 1'b0;

  task automatic drive_idle();
    for (int i = 0; i < NH; i++) bus.tl_h_i[i] = '0;
    bus.tl_d_i = '0;
  endtask

  function automatic bit busy();
    bit b = (dev_q.size() > 0) || dev_dv;
    for (int i = 0; i < NH; i++) b |= (hq[i].size() > 0);
    return b;
  endfunction

  task automatic tick();
    tl_h2d_t h;
    tl_d2h_t d;
    @(negedge clk);
    for (int i = 0; i < NH; i++) begin
      if (bus.tl_h_i[i].a_valid && bus.tl_h_o[i].a_ready) begin
        void'(hq[i].pop_front());
        acc_log.push_back(i);
      end
      if (bus.tl_h_o[i].d_valid && bus.tl_h_i[i].d_ready) rsp_log.push_back(i);
    end
    if (bus.tl_d_i.d_valid && bus.tl_d_o.d_ready) begin
      if (!unexp_cur && dev_q.size() > 0) void'(dev_q.pop_front());
      dev_dv = 1'b0;
    end
    if (bus.tl_d_o.a_valid && bus.tl_d_i.a_ready) dev_q.push_back(bus.tl_d_o.a_address);
    @(posedge clk);
    #1;
    for (int i = 0; i < NH; i++) begin
      h           = '0;
      h.a_valid   = (hq[i].size() > 0);
      h.a_address = (hq[i].size() > 0) ? hq[i][0] : 32'h0;
      h.a_opcode  = 3'd4;
      h.a_source  = 8'(i);
      h.a_mask    = 4'hF;
      h.d_ready   = ($urandom % 100) < p_dr;
      bus.tl_h_i[i] = h;
    end
    d         = '0;
    d.a_ready = ($urandom % 100) < p_ard;
    if (inject_unexp) begin
      inject_unexp = 1'b0;
      unexp_cur    = 1'b1;
      dev_dv       = 1'b0;
      d.d_valid    = 1'b1;
      d.d_data     = 32'hDEAD_BEEF;
    end else begin
      unexp_cur = 1'b0;
      if (!dev_dv && dev_q.size() > 0 && ($urandom % 100) < p_dv) dev_dv = 1'b1;
      d.d_valid = dev_dv;
      d.d_data  = dev_dv ? rsp_data(dev_q[0]) : 32'h0;
    end
    bus.tl_d_i = d;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_host_done(input int i, input int budget);
    int n = 0;
    while (hq[i].size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("host_wait_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NH; i++) hq[i].delete();
    dev_q.delete();
    dev_dv       = 1'b0;
    inject_unexp = 1'b0;
    unexp_cur    = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int e;
    drive_idle();
    do_reset();

    #2;
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_dev_a_valid", 32'(bus.tl_d_o.a_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    for (int i = 0; i < NH; i++) begin
      check("rst_a_ready", 32'(bus.tl_h_o[i].a_ready), 32'd0);
      check("rst_d_valid", 32'(bus.tl_h_o[i].d_valid), 32'd0);
    end
    repeat (3) tick();

    // both hosts contend continuously: grants and responses alternate 0,1,...
    for (int k = 0; k < 4; k++) begin
      hq[0].push_back(32'h1000 + 32'(k * 4));
      hq[1].push_back(32'h2000 + 32'(k * 4));
    end
    acc_log.delete();
    rsp_log.delete();
    drain(200);
    check("alt_grant_count", 32'(acc_log.size()), 32'd8);
    check("alt_rsp_count", 32'(rsp_log.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check("alt_grant_order", 32'((k < acc_log.size()) ? acc_log[k] : -1), 32'(k % 2));
      check("alt_rsp_order", 32'((k < rsp_log.size()) ? rsp_log[k] : -1), 32'(k % 2));
    end

    // host 1 stalls on the device while host 0 also requests
    p_ard = 0;
    hq[1].push_back(32'hCAFE_0010);
    tick();
    hq[0].push_back(32'hBEEF_0020);
    for (int k = 0; k < 5; k++) begin
      tick();
      #2;
      check("lock_addr", bus.tl_d_o.a_address, 32'hCAFE_0010);
      check("lock_a_valid", 32'(bus.tl_d_o.a_valid), 32'd1);
      check("lock_h0_a_ready", 32'(bus.tl_h_o[0].a_ready), 32'd0);
    end
    p_ard = 100;
    acc_log.delete();
    drain(200);
    check("lock_order0", 32'((acc_log.size() > 0) ? acc_log[0] : -1), 32'd1);
    check("lock_order1", 32'((acc_log.size() > 1) ? acc_log[1] : -1), 32'd0);

    // fill the tracking queue, then free one slot
    p_dv = 0;
    for (int k = 0; k < 5; k++) hq[0].push_back(32'h3000 + 32'(k * 4));
    for (int n = 0; n < 20 && hq[0].size() > 1; n++) tick();
    #2;
    check("full_outstanding", 32'(outstanding), 32'd4);
    check("full_a_ready", 32'(bus.tl_h_o[0].a_ready), 32'd0);
    check("full_dev_a_valid", 32'(bus.tl_d_o.a_valid), 32'd0);
    p_dv = 100;
    tick();
    #2;
    check("full_pop_d_valid", 32'(bus.tl_h_o[0].d_valid), 32'd1);
    check("full_pop_a_ready", 32'(bus.tl_h_o[0].a_ready), 32'd0);
    p_dv = 0;
    tick();
    #2;
    check("full_after_pop_outst", 32'(outstanding), 32'd3);
    check("full_after_pop_a_ready", 32'(bus.tl_h_o[0].a_ready), 32'd1);
    tick();
    #2;
    check("full_refill_outst", 32'(outstanding), 32'd4);
    check("full_fifth_accepted", 32'(hq[0].size()), 32'd0);
    p_dv = 100;
    drain(200);

    // concurrent push (host 1) and pop (host 0) at occupancy 2
    p_dv = 0;
    hq[0].push_back(32'h4000);
    wait_host_done(0, 20);
    hq[1].push_back(32'h4004);
    wait_host_done(1, 20);
    #2;
    check("cc_outst_before", 32'(outstanding), 32'd2);
    hq[1].push_back(32'h4008);
    p_dv = 100;
    tick();
    #2;
    check("cc_h0_d_valid", 32'(bus.tl_h_o[0].d_valid), 32'd1);
    check("cc_h1_a_ready", 32'(bus.tl_h_o[1].a_ready), 32'd1);
    tick();
    #2;
    check("cc_outst_after", 32'(outstanding), 32'd2);
    check("cc_head_h1", 32'(bus.tl_h_o[1].d_valid), 32'd1);
    check("cc_head_not_h0", 32'(bus.tl_h_o[0].d_valid), 32'd0);
    drain(200);

    // stray response with nothing outstanding
    inject_unexp = 1'b1;
    tick();
    #2;
    check("unexp_d_ready", 32'(bus.tl_d_o.d_ready), 32'd1);
    for (int i = 0; i < NH; i++) check("unexp_no_route", 32'(bus.tl_h_o[i].d_valid), 32'd0);
    e = int'(err);
    for (int k = 0; k < 4; k++) begin
      tick();
      #2;
      e += int'(err);
    end
    check("unexp_err_pulses", 32'(e), 32'd1);

    // randomized traffic
    for (int phase = 0; phase < 4; phase++) begin
      p_ard = $urandom_range(100, 30);
      p_dv  = $urandom_range(100, 20);
      p_dr  = $urandom_range(100, 40);
      for (int c = 0; c < 100; c++) begin
        for (int i = 0; i < NH; i++)
          if (hq[i].size() < 3 && ($urandom % 100) < 40) hq[i].push_back($urandom & 32'hFFFF_FFFC);
        tick();
      end
    end
    p_ard = 100; p_dv = 100; p_dr = 100;
    drain(500);

    // reset with requests in flight discards tracking
    p_dv = 0;
    hq[0].push_back(32'h5000);
    hq[1].push_back(32'h5004);
    drain_partial: for (int n = 0; n < 4; n++) tick();
    do_reset();
    #2;
    check("midrst_outstanding", 32'(outstanding), 32'd0);
    check("midrst_idle", 32'(idle), 32'd1);
    p_dv = 100;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NH; i++)
        if (hq[i].size() < 2 && ($urandom % 100) < 50) hq[i].push_back($urandom & 32'hFFFF_FFFC);
      tick();
    end
    drain(300);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
